// File: rtl/pcie_ep_pio_completer_if.sv
// TRN RX/TX bundle between the Virtex-6 integrated PCIe block (master) and the PIO completer (slave).
interface pcie_ep_pio_completer_if;
    logic [63:0] trn_rd;
    logic        trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rdst_rdy_n;
    logic [6:0]  trn_rbar_hit_n;
    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [15:0] cfg_completer_id;

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rbar_hit_n,
        input  trn_rdst_rdy_n,
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        output trn_tdst_rdy_n, cfg_completer_id
    );

    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rbar_hit_n,
        output trn_rdst_rdy_n,
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        input  trn_tdst_rdy_n, cfg_completer_id
    );
endinterface

// File: rtl/pcie_ep_pio_completer.sv
// BAR0 PIO target: 1-DW MWr32/MRd32 against a dword register file, CplD returned on TRN TX.
// Optional PCIE_CPL_UR_EN: rejected non-posted TLPs get a 3-DW Unsupported Request completion.
module pcie_ep_pio_completer #(
    parameter int ADDR_W      = 6,
    parameter int BAR_HIT_IDX = 0
) (
    input  logic                      trn_clk,
    input  logic                      trn_reset_n,
    pcie_ep_pio_completer_if.slave    trn
);

    typedef enum logic [2:0] {
        RX_HDR  = 3'd0,
        RX_ADDR = 3'd1,
        DRAIN   = 3'd2,
        TX_QW0  = 3'd3,
        TX_QW1  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [2:0]          tc_q, tc_d;
    logic [1:0]          attr_q, attr_d;
    logic [15:0]         req_id_q, req_id_d;
    logic [7:0]          tag_q, tag_d;
    logic [3:0]          fbe_q, fbe_d;
    logic [4:0]          addr_lo_q, addr_lo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [63:0]         td_q, td_d;
    logic                tsof_n_q, tsof_n_d;
    logic                teof_n_q, teof_n_d;
    logic                tsrc_rdy_n_q, tsrc_rdy_n_d;
    logic                trem_n_q, trem_n_d;
    logic                rdst_rdy_n_q, rdst_rdy_n_d;
`ifdef PCIE_CPL_UR_EN
    logic                ur_q, ur_d;
    logic                hdr_np_s;
`endif

    logic [31:0]         regs_q [0:(2**ADDR_W)-1];

    logic                rx_beat_s;
    logic                tx_ack_s;
    logic [6:0]          hdr_ft_s;
    logic [9:0]          hdr_len_s;
    logic                bar_hit_s;
    logic                hdr_ok_s;
    logic [ADDR_W-1:0]   idx_s;
    logic                wr_en_s;
    logic [63:0]         cpld_qw0_s;
    logic [63:0]         cpld_qw1_s;
    logic                unused_s;

    assign rx_beat_s = !trn.trn_rsrc_rdy_n && !rdst_rdy_n_q;
    assign tx_ack_s  = !tsrc_rdy_n_q && !trn.trn_tdst_rdy_n;
    assign hdr_ft_s  = trn.trn_rd[62:56];
    assign hdr_len_s = trn.trn_rd[41:32];
    assign bar_hit_s = !trn.trn_rbar_hit_n[BAR_HIT_IDX];
    assign hdr_ok_s  = ((hdr_ft_s == 7'h40) || (hdr_ft_s == 7'h00)) && (hdr_len_s == 10'd1) && bar_hit_s;
    // Dword address wraps: only the low ADDR_W bits of addr[31:2] select a register.
    assign idx_s     = trn.trn_rd[34 +: ADDR_W];
    assign unused_s  = ^{trn.trn_rd, trn.trn_rbar_hit_n};

    assign cpld_qw0_s = {3'b010, 5'b01010, 1'b0, tc_q, 4'b0000, 2'b00, attr_q, 2'b00, 10'd1,
                         trn.cfg_completer_id, 3'b000, 1'b0, 12'd4};
    assign cpld_qw1_s = {req_id_q, tag_q, 1'b0, addr_lo_q, 2'b00, rdata_q};

`ifdef PCIE_CPL_UR_EN
    assign hdr_np_s = (hdr_ft_s == 7'h00) || (hdr_ft_s == 7'h20) || (hdr_ft_s == 7'h02) ||
                      (hdr_ft_s == 7'h42) || (hdr_ft_s == 7'h04) || (hdr_ft_s == 7'h44) ||
                      (hdr_ft_s == 7'h05) || (hdr_ft_s == 7'h45);
`endif

    assign trn.trn_rdst_rdy_n = rdst_rdy_n_q;
    assign trn.trn_td         = td_q;
    assign trn.trn_trem_n     = trem_n_q;
    assign trn.trn_tsof_n     = tsof_n_q;
    assign trn.trn_teof_n     = teof_n_q;
    assign trn.trn_tsrc_rdy_n = tsrc_rdy_n_q;

    // Next-state and registered-output decode for the RX/TX sequencer.
    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        tc_d         = tc_q;
        attr_d       = attr_q;
        req_id_d     = req_id_q;
        tag_d        = tag_q;
        fbe_d        = fbe_q;
        addr_lo_d    = addr_lo_q;
        rdata_d      = rdata_q;
        td_d         = td_q;
        tsof_n_d     = tsof_n_q;
        teof_n_d     = teof_n_q;
        tsrc_rdy_n_d = tsrc_rdy_n_q;
        trem_n_d     = trem_n_q;
        wr_en_s      = 1'b0;
`ifdef PCIE_CPL_UR_EN
        ur_d         = ur_q;
`endif
        case (state_q)
            TX_QW0: begin
                if (tx_ack_s) begin
                    state_d  = TX_QW1;
                    tsof_n_d = 1'b1;
                    teof_n_d = 1'b0;
`ifdef PCIE_CPL_UR_EN
                    if (ur_q) begin
                        td_d     = {req_id_q, tag_q, 8'h00, 32'h0000_0000};
                        trem_n_d = 1'b1;
                    end else begin
                        td_d     = cpld_qw1_s;
                        trem_n_d = 1'b0;
                    end
`else
                    td_d     = cpld_qw1_s;
                    trem_n_d = 1'b0;
`endif
                end else begin
                    state_d = TX_QW0;
                end
            end
            TX_QW1: begin
                if (tx_ack_s) begin
                    state_d      = RX_HDR;
                    td_d         = 64'd0;
                    tsof_n_d     = 1'b1;
                    teof_n_d     = 1'b1;
                    tsrc_rdy_n_d = 1'b1;
                    trem_n_d     = 1'b0;
                end else begin
                    state_d = TX_QW1;
                end
            end
            RX_HDR, RX_ADDR, DRAIN: begin
                if (!rx_beat_s) begin
                    state_d = state_q;
                end else if (!trn.trn_rsof_n) begin
                    // Any SOF restarts decode, abandoning a partial TLP without side effects.
                    if (!trn.trn_reof_n) begin
                        state_d = RX_HDR;
`ifdef PCIE_CPL_UR_EN
                        ur_d    = 1'b0;
`endif
                    end else begin
                        is_wr_d  = (hdr_ft_s == 7'h40);
                        tc_d     = trn.trn_rd[54:52];
                        attr_d   = trn.trn_rd[45:44];
                        req_id_d = trn.trn_rd[31:16];
                        tag_d    = trn.trn_rd[15:8];
                        fbe_d    = trn.trn_rd[3:0];
                        state_d  = hdr_ok_s ? RX_ADDR : DRAIN;
`ifdef PCIE_CPL_UR_EN
                        ur_d     = !hdr_ok_s && hdr_np_s;
`endif
                    end
                end else if (state_q == RX_ADDR) begin
                    if (!trn.trn_reof_n) begin
                        if (is_wr_q) begin
                            wr_en_s = !trn.trn_rrem_n;
                            state_d = RX_HDR;
                        end else begin
                            rdata_d      = regs_q[idx_s];
                            addr_lo_d    = trn.trn_rd[38:34];
                            td_d         = cpld_qw0_s;
                            tsof_n_d     = 1'b0;
                            teof_n_d     = 1'b1;
                            tsrc_rdy_n_d = 1'b0;
                            trem_n_d     = 1'b0;
                            state_d      = TX_QW0;
                        end
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (state_q == DRAIN) begin
                    if (!trn.trn_reof_n) begin
`ifdef PCIE_CPL_UR_EN
                        if (ur_q) begin
                            td_d         = {3'b000, 5'b01010, 1'b0, tc_q, 4'b0000, 2'b00, attr_q, 2'b00, 10'd0,
                                            trn.cfg_completer_id, 3'b001, 1'b0, 12'd0};
                            tsof_n_d     = 1'b0;
                            teof_n_d     = 1'b1;
                            tsrc_rdy_n_d = 1'b0;
                            trem_n_d     = 1'b0;
                            state_d      = TX_QW0;
                        end else begin
                            state_d = RX_HDR;
                        end
`else
                        state_d = RX_HDR;
`endif
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = RX_HDR;
                end
            end
            default: begin
                state_d = RX_HDR;
            end
        endcase
        rdst_rdy_n_d = (state_d == TX_QW0) || (state_d == TX_QW1);
    end

    // Sequencer state, latched header fields and TRN output registers.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q      <= RX_HDR;
            is_wr_q      <= 1'b0;
            tc_q         <= 3'd0;
            attr_q       <= 2'd0;
            req_id_q     <= 16'd0;
            tag_q        <= 8'd0;
            fbe_q        <= 4'd0;
            addr_lo_q    <= 5'd0;
            rdata_q      <= 32'd0;
            td_q         <= 64'd0;
            tsof_n_q     <= 1'b1;
            teof_n_q     <= 1'b1;
            tsrc_rdy_n_q <= 1'b1;
            trem_n_q     <= 1'b0;
            rdst_rdy_n_q <= 1'b1;
`ifdef PCIE_CPL_UR_EN
            ur_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            is_wr_q      <= is_wr_d;
            tc_q         <= tc_d;
            attr_q       <= attr_d;
            req_id_q     <= req_id_d;
            tag_q        <= tag_d;
            fbe_q        <= fbe_d;
            addr_lo_q    <= addr_lo_d;
            rdata_q      <= rdata_d;
            td_q         <= td_d;
            tsof_n_q     <= tsof_n_d;
            teof_n_q     <= teof_n_d;
            tsrc_rdy_n_q <= tsrc_rdy_n_d;
            trem_n_q     <= trem_n_d;
            rdst_rdy_n_q <= rdst_rdy_n_d;
`ifdef PCIE_CPL_UR_EN
            ur_q         <= ur_d;
`endif
        end
    end

    // Dword register file with per-byte write enables from the first-DW byte enables.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            for (int i = 0; i < (2**ADDR_W); i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wr_en_s && fbe_q[b]) begin
                    regs_q[idx_s][8*b +: 8] <= trn.trn_rd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_ep_pio_completer.sv
// Directed self-checking bench for pcie_ep_pio_completer (honours PCIE_CPL_UR_EN when defined).
module tb_pcie_ep_pio_completer;

    logic trn_clk;
    logic trn_reset_n;
    int   errors;
    int   checks;

    localparam logic [6:0]  BAR0 = 7'b1111110;
    localparam logic [6:0]  BAR1 = 7'b1111101;
    localparam logic [15:0] CPL_ID = 16'h0A08;

    pcie_ep_pio_completer_if tif ();

    pcie_ep_pio_completer #(.ADDR_W(6), .BAR_HIT_IDX(0)) dut (
        .trn_clk     (trn_clk),
        .trn_reset_n (trn_reset_n),
        .trn         (tif)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    task automatic chk1(input string nm, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", nm, obs, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic sof, input logic eof,
                              input logic rrem, input logic [6:0] bar);
        tif.trn_rd         = d;
        tif.trn_rsof_n     = !sof;
        tif.trn_reof_n     = !eof;
        tif.trn_rrem_n     = rrem;
        tif.trn_rbar_hit_n = bar;
        tif.trn_rsrc_rdy_n = 1'b0;
    endtask

    // Present one RX beat and wait (bounded) until it is accepted.
    task automatic send_beat(input logic [63:0] d, input logic sof, input logic eof,
                             input logic rrem, input logic [6:0] bar);
        int n = 0;
        drive_beat(d, sof, eof, rrem, bar);
        while (tif.trn_rdst_rdy_n !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk1("rx_accept_wait", tif.trn_rdst_rdy_n, 1'b0);
        tick();
        tif.trn_rsrc_rdy_n = 1'b1;
        tif.trn_rsof_n     = 1'b1;
        tif.trn_reof_n     = 1'b1;
    endtask

    task automatic mwr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                       input logic [6:0] bar);
        send_beat({32'h4000_0001, 16'h0000, 8'h00, 4'h0, be}, 1'b1, 1'b0, 1'b0, bar);
        send_beat({addr, data}, 1'b0, 1'b1, 1'b0, bar);
    endtask

    task automatic mrd_beats(input logic [31:0] dw0, input logic [31:0] addr,
                             input logic [15:0] req, input logic [7:0] tag);
        send_beat({dw0, req, tag, 8'h0F}, 1'b1, 1'b0, 1'b0, BAR0);
        send_beat({addr, 32'h0000_0000}, 1'b0, 1'b1, 1'b1, BAR0);
    endtask

    // Read request with zero TX backpressure; checks both completion beats and RX re-open timing.
    task automatic mrd_check(input string nm, input logic [31:0] dw0, input logic [31:0] addr,
                             input logic [15:0] req, input logic [7:0] tag,
                             input logic [63:0] e0, input logic [63:0] e1, input logic etrem);
        mrd_beats(dw0, addr, req, tag);
        chk1({nm, "_qw0_vld"}, tif.trn_tsrc_rdy_n, 1'b0);
        chk1({nm, "_qw0_sof"}, tif.trn_tsof_n, 1'b0);
        chk64({nm, "_qw0"}, tif.trn_td, e0);
        chk1({nm, "_rx_stall"}, tif.trn_rdst_rdy_n, 1'b1);
        tick();
        chk64({nm, "_qw1"}, tif.trn_td, e1);
        chk1({nm, "_qw1_eof"}, tif.trn_teof_n, 1'b0);
        chk1({nm, "_qw1_rem"}, tif.trn_trem_n, etrem);
        tick();
        chk1({nm, "_tx_idle"}, tif.trn_tsrc_rdy_n, 1'b1);
        chk1({nm, "_rx_open"}, tif.trn_rdst_rdy_n, 1'b0);
    endtask

    initial begin
        logic saw_tx;
        errors = 0;
        checks = 0;
        trn_reset_n          = 1'b0;
        tif.trn_rd           = 64'd0;
        tif.trn_rrem_n       = 1'b0;
        tif.trn_rsof_n       = 1'b1;
        tif.trn_reof_n       = 1'b1;
        tif.trn_rsrc_rdy_n   = 1'b1;
        tif.trn_rbar_hit_n   = 7'h7F;
        tif.trn_tdst_rdy_n   = 1'b0;
        tif.cfg_completer_id = CPL_ID;

        repeat (3) tick();
        chk1("rst_rdst_rdy_n", tif.trn_rdst_rdy_n, 1'b1);
        chk1("rst_tsrc_rdy_n", tif.trn_tsrc_rdy_n, 1'b1);
        chk1("rst_tsof_n", tif.trn_tsof_n, 1'b1);
        chk1("rst_teof_n", tif.trn_teof_n, 1'b1);
        chk64("rst_td", tif.trn_td, 64'd0);
        chk1("rst_trem_n", tif.trn_trem_n, 1'b0);
        trn_reset_n = 1'b1;
        repeat (2) tick();
        chk1("post_rst_rx_open", tif.trn_rdst_rdy_n, 1'b0);

        // Full-word write then read back.
        mwr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, BAR0);
        mrd_check("rd10", 32'h0000_0001, 32'h0000_0010, 16'h0100, 8'h05,
                  64'h4A00_0001_0A08_0004, 64'h0100_0510_DEAD_BEEF, 1'b0);

        // Partial byte enables over a cleared register.
        mwr(32'h0000_0020, 32'h1122_3344, 4'h3, BAR0);
        mrd_check("rd20_be", 32'h0000_0001, 32'h0000_0020, 16'h0100, 8'h06,
                  64'h4A00_0001_0A08_0004, 64'h0100_0620_0000_3344, 1'b0);

        // Address wrap: 0x104 aliases dword index 1 (byte 0x04).
        mwr(32'h0000_0004, 32'hCAFE_F00D, 4'hF, BAR0);
        mrd_check("rd104_wrap", 32'h0000_0001, 32'h0000_0104, 16'h0100, 8'h08,
                  64'h4A00_0001_0A08_0004, 64'h0100_0804_CAFE_F00D, 1'b0);

        // Write with only BAR1 hit must be ignored.
        mwr(32'h0000_0010, 32'h1234_5678, 4'hF, BAR1);
        mrd_check("rd10_bar1", 32'h0000_0001, 32'h0000_0010, 16'h0100, 8'h09,
                  64'h4A00_0001_0A08_0004, 64'h0100_0910_DEAD_BEEF, 1'b0);

        // TX backpressure for 20 cycles with TC=3, attr=2 and a new TLP waiting on RX.
        tif.trn_tdst_rdy_n = 1'b1;
        mrd_beats(32'h0030_2001, 32'h0000_0020, 16'h0200, 8'h07);
        drive_beat({32'h4000_0001, 16'h0000, 8'h00, 4'h0, 4'hF}, 1'b1, 1'b0, 1'b0, BAR0);
        for (int i = 0; i < 20; i++) begin
            chk64("bp_qw0_hold", tif.trn_td, 64'h4A30_2001_0A08_0004);
            chk1("bp_tsrc", tif.trn_tsrc_rdy_n, 1'b0);
            chk1("bp_rx_stall", tif.trn_rdst_rdy_n, 1'b1);
            tick();
        end
        tif.trn_tdst_rdy_n = 1'b0;
        tick();
        chk64("bp_qw1", tif.trn_td, 64'h0200_0720_0000_3344);
        tick();
        chk1("bp_tx_idle", tif.trn_tsrc_rdy_n, 1'b1);
        send_beat({32'h4000_0001, 16'h0000, 8'h00, 4'h0, 4'hF}, 1'b1, 1'b0, 1'b0, BAR0);
        send_beat({32'h0000_0030, 32'hA5A5_5A5A}, 1'b0, 1'b1, 1'b0, BAR0);
        mrd_check("rd30_stalled_wr", 32'h0000_0001, 32'h0000_0030, 16'h0100, 8'h0A,
                  64'h4A00_0001_0A08_0004, 64'h0100_0A30_A5A5_5A5A, 1'b0);

        // Read with length 2 is rejected.
`ifdef PCIE_CPL_UR_EN
        mrd_check("len2_ur", 32'h0000_0002, 32'h0000_0010, 16'h0300, 8'h0B,
                  64'h0A00_0000_0A08_2000, 64'h0300_0B00_0000_0000, 1'b1);
`else
        mrd_beats(32'h0000_0002, 32'h0000_0010, 16'h0300, 8'h0B);
        saw_tx = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (tif.trn_tsrc_rdy_n === 1'b0) saw_tx = 1'b1;
            tick();
        end
        chk1("len2_no_tx", saw_tx, 1'b0);
        chk1("len2_rx_open", tif.trn_rdst_rdy_n, 1'b0);
`endif

        // Asynchronous reset between TX_QW0 and TX_QW1.
        tif.trn_tdst_rdy_n = 1'b1;
        mrd_beats(32'h0000_0001, 32'h0000_0010, 16'h0100, 8'h05);
        chk1("rstmid_qw0_vld", tif.trn_tsrc_rdy_n, 1'b0);
        #2;
        trn_reset_n = 1'b0;
        #1;
        chk1("rstmid_tsrc", tif.trn_tsrc_rdy_n, 1'b1);
        chk1("rstmid_tsof", tif.trn_tsof_n, 1'b1);
        chk64("rstmid_td", tif.trn_td, 64'd0);
        tick();
        trn_reset_n        = 1'b1;
        tif.trn_tdst_rdy_n = 1'b0;
        repeat (2) tick();
        chk1("rstmid_no_tx", tif.trn_tsrc_rdy_n, 1'b1);
        mrd_check("rd10_cleared", 32'h0000_0001, 32'h0000_0010, 16'h0100, 8'h05,
                  64'h4A00_0001_0A08_0004, 64'h0100_0510_0000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
